// File: rtl/opr_sequencer.sv
// Step sequencer for the PDP-8 OPR instruction: issues one datapath strobe group per cycle, skipping idle steps.
// Optional Group 3 MQ step compiled in with `define OPR_GROUP3_EN.
module opr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] ir,
    input  logic        ac_zero,
    input  logic        ac_neg,
    input  logic        link,
    output logic        busy,
    output logic        done,
    output logic        clr_ac,
    output logic        clr_l,
    output logic        cma,
    output logic        cml,
    output logic        iac,
    output logic        rot_l,
    output logic        rot_r,
    output logic        bsw,
    output logic        or_sr,
    output logic        halt,
    output logic        mqa,
    output logic        mql,
    output logic        skip
);

    typedef enum logic [3:0] {
        IDLE, S_CLR, S_CMP, S_INC, S_ROT1, S_ROT2, S_SKP, S_SR, S_MQ, S_DONE
    } state_t;

    typedef enum logic [1:0] {GRP1, GRP2, GRP3} grp_t;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] ir_q;
    logic        skip_q;
    logic        accept;
    logic        skip_cond;
    grp_t        grp_q;

    function automatic grp_t grp_of(input logic [11:0] i);
        if (!i[8])
            return GRP1;
        else if (!i[0])
            return GRP2;
        else
            return GRP3;
    endfunction

    function automatic logic step_en(input state_t s, input logic [11:0] i);
        grp_t g;
        logic one_rot;
        logic en;
        g       = grp_of(i);
        one_rot = i[3] ^ i[2];
        en      = 1'b0;
        case (s)
            S_CLR:  en = (g == GRP1) ? (i[7] | i[6]) : i[7];
            S_CMP:  en = (g == GRP1) && (i[5] | i[4]);
            S_INC:  en = (g == GRP1) && i[0];
            S_ROT1: en = (g == GRP1) && (one_rot || (i[1] && i[3:2] == 2'b00));
            S_ROT2: en = (g == GRP1) && i[1] && one_rot;
            S_SKP:  en = (g == GRP2);
            S_SR:   en = (g == GRP2) && (i[2] | i[1]);
`ifdef OPR_GROUP3_EN
            S_MQ:   en = (g == GRP3) && (i[6] | i[4]);
`else
            S_MQ:   en = 1'b0;
`endif
            default: en = 1'b0;
        endcase
        return en;
    endfunction

    // One global step order is consistent with every group's order; step_en filters by group.
    function automatic state_t step_at(input int k);
        case (k)
            0:       return S_SKP;
            1:       return S_CLR;
            2:       return S_CMP;
            3:       return S_INC;
            4:       return S_ROT1;
            5:       return S_ROT2;
            6:       return S_SR;
            7:       return S_MQ;
            default: return S_DONE;
        endcase
    endfunction

    function automatic state_t next_step(input state_t cur, input logic [11:0] i);
        state_t nxt;
        logic   past;
        nxt  = S_DONE;
        past = (cur == IDLE);
        for (int k = 0; k < 8; k++) begin
            if (past && nxt == S_DONE && step_en(step_at(k), i))
                nxt = step_at(k);
            if (step_at(k) == cur)
                past = 1'b1;
        end
        return nxt;
    endfunction

    assign accept    = (state_q == IDLE) && start && (ir[11:9] == 3'b111);
    assign grp_q     = grp_of(ir_q);
    assign skip_cond = (ir_q[6] & ac_neg) | (ir_q[5] & ac_zero) | (ir_q[4] & link);
    assign skip      = skip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= 12'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q   <= ir;
                skip_q <= 1'b0;
            end else if (state_q == S_SKP) begin
                skip_q <= ir_q[3] ^ skip_cond;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = next_step(IDLE, ir);
            S_DONE:  state_d = IDLE;
            default: state_d = next_step(state_q, ir_q);
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == S_DONE);
        clr_ac = 1'b0;
        clr_l  = 1'b0;
        cma    = 1'b0;
        cml    = 1'b0;
        iac    = 1'b0;
        rot_l  = 1'b0;
        rot_r  = 1'b0;
        bsw    = 1'b0;
        or_sr  = 1'b0;
        halt   = 1'b0;
        mqa    = 1'b0;
        mql    = 1'b0;
        case (state_q)
            S_CLR: begin
                clr_ac = ir_q[7];
                clr_l  = (grp_q == GRP1) && ir_q[6];
            end
            S_CMP: begin
                cma = ir_q[5];
                cml = ir_q[4];
            end
            S_INC:  iac = ir_q[0];
            S_ROT1, S_ROT2: begin
                // Both rotate bits together is undefined on the PDP-8; emit nothing.
                if (ir_q[1] && ir_q[3:2] == 2'b00) begin
                    bsw = (state_q == S_ROT1);
                end else if (ir_q[3] ^ ir_q[2]) begin
                    rot_r = ir_q[3];
                    rot_l = ir_q[2];
                end
            end
            S_SR: begin
                or_sr = ir_q[2];
                halt  = ir_q[1];
            end
`ifdef OPR_GROUP3_EN
            S_MQ: begin
                mqa = ir_q[6];
                mql = ir_q[4];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_opr_sequencer.sv
// Directed bench for opr_sequencer; output vector per cycle compared against hand-derived tables.
module tb_opr_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] ir;
    logic        ac_zero;
    logic        ac_neg;
    logic        link;
    logic        busy, done, clr_ac, clr_l, cma, cml, iac, rot_l, rot_r, bsw;
    logic        or_sr, halt, mqa, mql, skip;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;

    opr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ir(ir),
        .ac_zero(ac_zero), .ac_neg(ac_neg), .link(link),
        .busy(busy), .done(done), .clr_ac(clr_ac), .clr_l(clr_l),
        .cma(cma), .cml(cml), .iac(iac), .rot_l(rot_l), .rot_r(rot_r),
        .bsw(bsw), .or_sr(or_sr), .halt(halt), .mqa(mqa), .mql(mql),
        .skip(skip)
    );

    // [13]busy [12]done [11]clr_ac [10]clr_l [9]cma [8]cml [7]iac [6]rot_l [5]rot_r [4]bsw [3]or_sr [2]halt [1]mqa [0]mql
    assign obs = {busy, done, clr_ac, clr_l, cma, cml, iac, rot_l, rot_r, bsw, or_sr, halt, mqa, mql};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at the sampling point of cycle T+1.
    task automatic issue(input logic [11:0] op);
        @(negedge clk);
        ir    = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ir = 12'o0;
        ac_zero = 1'b0; ac_neg = 1'b0; link = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 14'h0000 || skip !== 1'b0) begin
            errors++;
            $display("FAIL reset obs=%h skip=%b expected 0000/0", obs, skip);
        end
        reset = 1'b0;
    endtask

    task automatic test_group1;
        logic [11:0] ops [0:6];
        logic [13:0] ex  [0:6][0:7];
        int          len [0:6];
        ops[0] = 12'o7300; len[0] = 3; ex[0][0:2] = '{14'h2C00, 14'h3000, 14'h0000};
        ops[1] = 12'o7006; len[1] = 4; ex[1][0:3] = '{14'h2040, 14'h2040, 14'h3000, 14'h0000};
        ops[2] = 12'o7002; len[2] = 3; ex[2][0:2] = '{14'h2010, 14'h3000, 14'h0000};
        ops[3] = 12'o7000; len[3] = 2; ex[3][0:1] = '{14'h3000, 14'h0000};
        ops[4] = 12'o7327; len[4] = 7;
        ex[4][0:6] = '{14'h2C00, 14'h2100, 14'h2080, 14'h2040, 14'h2040, 14'h3000, 14'h0000};
        ops[5] = 12'o7010; len[5] = 3; ex[5][0:2] = '{14'h2020, 14'h3000, 14'h0000};
        ops[6] = 12'o7016; len[6] = 2; ex[6][0:1] = '{14'h3000, 14'h0000};
        for (int t = 0; t < 7; t++) begin
            issue(ops[t]);
            for (int k = 0; k < len[t]; k++) begin
                checks++;
                if (obs !== ex[t][k]) begin
                    errors++;
                    $display("FAIL g1 op=%o cyc=T+%0d obs=%h expected %h", ops[t], k + 1, obs, ex[t][k]);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (skip !== 1'b0) begin
            errors++;
            $display("FAIL g1_skip obs=%b expected 0", skip);
        end
    endtask

    task automatic test_skip;
        logic [11:0] ops [0:5];
        logic [3:0]  cfg [0:5];
        ops[0] = 12'o7450; cfg[0] = 4'b0001;
        ops[1] = 12'o7500; cfg[1] = 4'b0000;
        ops[2] = 12'o7410; cfg[2] = 4'b0001;
        ops[3] = 12'o7500; cfg[3] = 4'b1001;
        ops[4] = 12'o7420; cfg[4] = 4'b0011;
        ops[5] = 12'o7430; cfg[5] = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            ac_neg = cfg[t][3]; ac_zero = cfg[t][2]; link = cfg[t][1];
            issue(ops[t]);
            checks++;
            if (obs !== 14'h2000 || skip !== 1'b0) begin
                errors++;
                $display("FAIL skp_step op=%o obs=%h skip=%b expected 2000/0", ops[t], obs, skip);
            end
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++;
                if (skip !== cfg[t][0] || obs !== (k == 0 ? 14'h3000 : 14'h0000)) begin
                    errors++;
                    $display("FAIL skip op=%o cyc=T+%0d obs=%h skip=%b expected skip %b", ops[t], k + 2, obs, skip, cfg[t][0]);
                end
            end
        end
        ac_neg = 1'b0; ac_zero = 1'b0; link = 1'b0;
    endtask

    task automatic test_group2_ops;
        logic [11:0] ops [0:1];
        logic [13:0] ex  [0:1][0:4];
        int          len [0:1];
        ops[0] = 12'o7402; len[0] = 4; ex[0][0:3] = '{14'h2000, 14'h2004, 14'h3000, 14'h0000};
        ops[1] = 12'o7704; len[1] = 5; ex[1][0:4] = '{14'h2000, 14'h2800, 14'h2008, 14'h3000, 14'h0000};
        for (int t = 0; t < 2; t++) begin
            issue(ops[t]);
            for (int k = 0; k < len[t]; k++) begin
                checks++;
                if (obs !== ex[t][k]) begin
                    errors++;
                    $display("FAIL g2 op=%o cyc=T+%0d obs=%h expected %h", ops[t], k + 1, obs, ex[t][k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_group3;
        logic [11:0] ops [0:1];
        logic [13:0] ex  [0:1][0:3];
        int          len [0:1];
        ops[0] = 12'o7521;
        ops[1] = 12'o7621;
`ifdef OPR_GROUP3_EN
        len[0] = 3; ex[0][0:2] = '{14'h2003, 14'h3000, 14'h0000};
        len[1] = 4; ex[1][0:3] = '{14'h2800, 14'h2001, 14'h3000, 14'h0000};
`else
        len[0] = 2; ex[0][0:1] = '{14'h3000, 14'h0000};
        len[1] = 3; ex[1][0:2] = '{14'h2800, 14'h3000, 14'h0000};
`endif
        for (int t = 0; t < 2; t++) begin
            issue(ops[t]);
            for (int k = 0; k < len[t]; k++) begin
                checks++;
                if (obs !== ex[t][k]) begin
                    errors++;
                    $display("FAIL g3 op=%o cyc=T+%0d obs=%h expected %h", ops[t], k + 1, obs, ex[t][k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back;
        issue(12'o7300);
        ir = 12'o7000; start = 1'b1;
        checks++;
        if (obs !== 14'h2C00) begin
            errors++; $display("FAIL b2b_t1 obs=%h expected 2c00", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== 14'h3000) begin
            errors++; $display("FAIL b2b_done obs=%h expected 3000", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== 14'h0000) begin
            errors++; $display("FAIL b2b_idle obs=%h expected 0000", obs);
        end
        @(negedge clk);
        ir = 12'o5000;
        checks++;
        if (obs !== 14'h3000) begin
            errors++; $display("FAIL b2b_accept obs=%h expected 3000", obs);
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs !== 14'h0000) begin
            errors++; $display("FAIL non_opr obs=%h expected 0000", obs);
        end
    endtask

    task automatic test_reset_mid;
        issue(12'o7410);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (skip !== 1'b0) begin
            errors++; $display("FAIL reset_skip obs=%b expected 0", skip);
        end
        issue(12'o7327);
        checks++;
        if (obs !== 14'h2C00) begin
            errors++; $display("FAIL rst_t1 obs=%h expected 2c00", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== 14'h2100) begin
            errors++; $display("FAIL rst_t2 obs=%h expected 2100", obs);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 14'h0000 || skip !== 1'b0) begin
            errors++; $display("FAIL rst_t3 obs=%h skip=%b expected 0000/0", obs, skip);
        end
        ir = 12'o7300; start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 14'h0000) begin
            errors++; $display("FAIL rst_block obs=%h expected 0000", obs);
        end
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs !== 14'h2C00) begin
            errors++; $display("FAIL rst_accept obs=%h expected 2c00", obs);
        end
        @(negedge clk);
        checks++;
        if (obs !== 14'h3000) begin
            errors++; $display("FAIL rst_done obs=%h expected 3000", obs);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_group1();
        test_skip();
        test_group2_ops();
        test_group3();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opr_sequencer.md
OPR_SEQUENCER -- requirements
Module: opr_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all other behaviour is fixed by REQ-002..REQ-016.
REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to execute the OPR instruction on ir
- ir  in  12  instruction word; captured only when start is accepted
- ac_zero  in  1  datapath AC==0 status
- ac_neg  in  1  datapath AC[11] status
- link  in  1  datapath Link status
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- clr_ac  out  1  clear-AC strobe
- clr_l  out  1  clear-Link strobe
- cma  out  1  complement-AC strobe
- cml  out  1  complement-Link strobe
- iac  out  1  increment-AC strobe
- rot_l  out  1  rotate-left-one strobe
- rot_r  out  1  rotate-right-one strobe
- bsw  out  1  byte-swap strobe
- or_sr  out  1  OR switch register into AC strobe
- halt  out  1  halt request pulse
- mqa  out  1  OR MQ into AC strobe
- mql  out  1  load MQ from AC, clear AC strobe
- skip  out  1  skip decision for the last completed instruction

Function
REQ-003 Start SHALL be accepted only in IDLE with ir[11:9]==3'b111; otherwise it SHALL be ignored, and ir SHALL be latched on acceptance.
REQ-004 Group decode on the latched ir SHALL be: G1 when ir[8]==0; G2 when ir[8]==1 and ir[0]==0; G3 when ir[8]==1 and ir[0]==1.
REQ-005 The states SHALL be IDLE, S_CLR, S_CMP, S_INC, S_ROT1, S_ROT2, S_SKP, S_SR, S_MQ and S_DONE; a state whose step has no enabled bits SHALL be bypassed without consuming a cycle.
REQ-006 G1 steps SHALL be, in order:
- S_CLR: clr_ac=ir[7], clr_l=ir[6]
- S_CMP: cma=ir[5], cml=ir[4]
- S_INC: iac=ir[0]
- S_ROT1: rot_r=ir[3], rot_l=ir[2]; bsw=1 instead when ir[1]=1 and ir[3:2]=00
- S_ROT2 (ir[1]=1 and exactly one of ir[3:2] set): repeats the S_ROT1 rotate strobe
REQ-007 In G1, ir[3:2]==2'b11 SHALL suppress all rotate and bsw strobes, and the rotate step SHALL be bypassed.
REQ-008 G2 steps SHALL be, in order:
- S_SKP: always executed; samples ac_neg, ac_zero and link
- S_CLR: clr_ac=ir[7]
- S_SR: or_sr=ir[2], halt=ir[1]
REQ-009 The G2 skip condition SHALL be c = (ir[6]&ac_neg)|(ir[5]&ac_zero)|(ir[4]&link), with skip = c when ir[3]==0 and skip = ~c when ir[3]==1; skip SHALL be registered at the S_SKP edge and held until the next accepted start, which clears it to 0.
REQ-010 G3 steps SHALL be, in order:
- S_CLR: clr_ac=ir[7]
- S_MQ: mqa=ir[6], mql=ir[4], both in the same cycle
REQ-011 Each strobe SHALL be high for exactly one cycle per step, with at most one step per cycle, and all strobes SHALL be 0 outside their step.
REQ-012 Timing from the accept cycle T:
- first active step at T+1
- done at T+1+N, where N is the number of active steps (NOP 7000: done at T+1)
- busy high from T+1 through the done cycle inclusive
REQ-013 Start asserted while busy SHALL be ignored, and start in the done cycle SHALL also be ignored; the next acceptance is no earlier than done+1.

Reset
REQ-014 Reset SHALL have priority over start, including mid-sequence, and SHALL take effect at the same edge.
REQ-015 After reset:
- state = IDLE
- busy, done and all strobes = 0
- skip = 0
- latched ir = 0

Configuration
REQ-016 Group 3 MQ support SHALL be controlled by the macro OPR_GROUP3_EN:
- defined: REQ-010 in full
- undefined: G3 executes only S_CLR; S_MQ is never entered; mqa and mql are tied 0

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ir=7300, start at T -> clr_ac=clr_l=1 at T+1; done at T+2; skip=0.
- ir=7006 (RTL) -> rot_l=1 at T+1 and T+2; rot_r=0; done at T+3; ir=7002 -> bsw at T+1; done at T+2.
- ir=7450 (SNA), ac_zero=0 -> skip=1 from T+2; ir=7500 (SMA), ac_neg=0 -> skip=0; ir=7410 (SKP) -> skip=1.
- ir=7402 (HLT) -> S_SKP at T+1, halt at T+2, done at T+3; ir=7000 -> done at T+1, no strobes.
- ir=7521 (SWP) with OPR_GROUP3_EN -> mqa=mql=1 at T+1, done at T+2; without it -> done at T+1, mqa=mql=0.
- ir=7327, reset at T+2 -> all outputs 0 at T+3; start at T+3 blocked by reset; start at T+4 accepted.
